// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store.
// Data side has priority; a starvation counter guarantees fetch progress.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [3:0]        dm_w_en,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e     state_q, state_d;
  logic [2:0] lat_q, lat_d;
  logic [3:0] starve_q, starve_d;
  logic       owner_q, owner_d;

  logic win, starved, if_win, dm_win, rd_gnt, ret;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      starve_q <= '0;
      owner_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  // the return cycle of a read also opens the window, so reads chain
  always_comb begin
    win     = rst && (state_q == IDLE || lat_q == 3'd1);
    starved = starve_q == 4'(STARVE_MAX);
    if_win  = win && if_req && (!dm_req || starved);
    dm_win  = win && dm_req && !if_win;
    rd_gnt  = if_win || (dm_win && dm_w_en == 4'h0);
    ret     = state_q == WAIT && lat_q == 3'd1;
  end

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    if (state_q == WAIT) begin
      lat_d = lat_q - 3'd1;
      if (lat_q == 3'd1) state_d = IDLE;
    end
    if (rd_gnt) begin
      state_d = WAIT;
      lat_d   = 3'(LAT);
      owner_d = dm_win;
    end
    if (!if_req || if_win) starve_d = '0;
    else if (!starved)     starve_d = starve_q + 4'd1;
  end

  always_comb begin
    if_gnt    = if_win;
    dm_gnt    = dm_win;
    mem_en    = if_win || dm_win;
    mem_addr  = '0;
    mem_w_en  = '0;
    mem_wdata = '0;
    if (if_win) begin
      mem_addr = if_addr;
    end else if (dm_win) begin
      mem_addr  = dm_addr;
      mem_w_en  = dm_w_en;
      mem_wdata = dm_wdata;
    end
    busy      = state_q == WAIT;
    if_rvalid = ret && !owner_q;
    dm_rvalid = ret && owner_q;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a latency-modelled SRAM.
// Per-cycle arbitration model plus queued read responses.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [3:0]    dm_w_en = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic [3:0]    mem_w_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_w_en(dm_w_en),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE0000 ^ (32'(i) * 32'h01010101);
  endfunction

  function automatic logic [31:0] apply_wr(logic [31:0] old, logic [3:0] we,
                                           logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // SRAM environment driven by the DUT memory port
  logic [31:0] sram [int];
  logic [31:0] pipe [LAT];
  assign mem_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    int i;
    logic [31:0] w;
    i = int'(mem_addr[5:2]);
    w = sram.exists(i) ? sram[i] : init_word(i);
    if (mem_en && mem_w_en != 4'h0) sram[i] = apply_wr(w, mem_w_en, mem_wdata);
    for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
    pipe[0] <= (mem_en && mem_w_en == 4'h0) ? w : $urandom;
  end

  // reference memory, updated from the requests the bench issues
  logic [31:0] expm [int];

  function automatic logic [31:0] rd_exp(logic [AW-1:0] a);
    int i;
    i = int'(a[5:2]);
    return expm.exists(i) ? expm[i] : init_word(i);
  endfunction

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t if_q[$];
  rsp_t dm_q[$];

  int last_rd = -1000;
  int starve  = 0;
  logic if_g = 1'b0;
  logic dm_g = 1'b0;

  task automatic check_cycle();
    logic e_if, e_dm, win, e_busy;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_we;
    e_if = 1'b0; e_dm = 1'b0; e_busy = 1'b0;
    if (!rst) begin
      last_rd = -1000;
      starve  = 0;
      if_q.delete();
      dm_q.delete();
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_dm_rvalid", dm_rvalid, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
    end else begin
      win    = cyc >= last_rd + LAT;
      e_busy = cyc > last_rd && cyc <= last_rd + LAT;
      e_if   = win && if_req && (!dm_req || starve == SMAX);
      e_dm   = win && dm_req && !e_if;
    end
    e_addr = e_if ? if_addr : (e_dm ? dm_addr : '0);
    e_we   = e_dm ? dm_w_en : '0;
    e_wd   = e_dm ? dm_wdata : '0;
    chk("if_gnt", if_gnt, e_if);
    chk("dm_gnt", dm_gnt, e_dm);
    chk("mem_en", mem_en, e_if | e_dm);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_w_en", mem_w_en, e_we);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("busy", busy, e_busy);
    if (rst) begin
      if (if_req && !e_if) starve = (starve < SMAX) ? starve + 1 : SMAX;
      else starve = 0;
      if (e_if) begin
        if_q.push_back('{cyc + LAT, rd_exp(if_addr)});
        last_rd = cyc;
      end
      if (e_dm) begin
        if (dm_w_en == 4'h0) begin
          dm_q.push_back('{cyc + LAT, rd_exp(dm_addr)});
          last_rd = cyc;
        end else begin
          expm[int'(dm_addr[5:2])] = apply_wr(rd_exp(dm_addr), dm_w_en, dm_wdata);
        end
      end
    end
    if_g = if_gnt;
    dm_g = dm_gnt;
  endtask

  // response monitor
  always @(negedge clk) begin
    logic ev;
    logic [31:0] ed;
    if (rst) begin
      ev = if_q.size() > 0 && if_q[0].due == cyc;
      ed = '0;
      if (ev) ed = if_q.pop_front().data;
      chk("if_rvalid", if_rvalid, ev);
      chk("if_rdata", if_rdata, ed);
      ev = dm_q.size() > 0 && dm_q[0].due == cyc;
      ed = '0;
      if (ev) ed = dm_q.pop_front().data;
      chk("dm_rvalid", dm_rvalid, ev);
      chk("dm_rdata", dm_rdata, ed);
    end
  end

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    if (if_g || !if_req) begin
      if_req  = $urandom_range(0, 99) < 60;
      if_addr = 32'($urandom_range(0, 15)) << 2;
    end
    if (dm_g || !dm_req) begin
      dm_req   = $urandom_range(0, 99) < 75;
      dm_addr  = 32'($urandom_range(0, 15)) << 2;
      dm_w_en  = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      dm_wdata = $urandom;
    end
  endtask

  initial begin
    step();
    step();
    rst = 1'b1;
    // single fetch
    if_req = 1'b1; if_addr = 32'h10;
    step();
    if_req = 1'b0;
    repeat (3) step();
    // simultaneous requests: data first
    if_req = 1'b1; if_addr = 32'h14;
    dm_req = 1'b1; dm_addr = 32'h30; dm_w_en = 4'h0;
    step();
    dm_req = 1'b0;
    repeat (LAT) step();
    if_req = 1'b0;
    repeat (3) step();
    // partial store, then read it back
    dm_req = 1'b1; dm_addr = 32'h20; dm_w_en = 4'h3; dm_wdata = 32'h1234ABCD;
    step();
    dm_req = 1'b0;
    step();
    dm_req = 1'b1; dm_w_en = 4'h0;
    step();
    dm_req = 1'b0;
    repeat (3) step();
    // continuous stores against a waiting fetch
    dm_req = 1'b1; dm_w_en = 4'hF; dm_addr = 32'h24;
    if_req = 1'b1; if_addr = 32'h18;
    repeat (14) begin
      dm_wdata = $urandom;
      step();
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (3) step();
    // back-to-back loads
    dm_req = 1'b1; dm_w_en = 4'h0; dm_addr = 32'h0;
    step();
    dm_addr = 32'h4;
    repeat (LAT) step();
    dm_req = 1'b0;
    repeat (3) step();
    // reset one cycle after a load grant
    dm_req = 1'b1; dm_addr = 32'h8;
    step();
    dm_req = 1'b0;
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h1C;
    step();
    step();
    rst = 1'b1;
    step();
    chk("if_gnt_after_reset", if_g, 1);
    if_req = 1'b0;
    repeat (3) step();
    // random traffic
    repeat (3000) begin
      drive_random();
      step();
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (LAT + 3) step();
    chk("if_q_drained", 64'(if_q.size()), 0);
    chk("dm_q_drained", 64'(dm_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port SRAM between the instruction-fetch requester (PC side) and the load/store requester (ALU-address side). This lets the core run from a unified memory instead of separate IM/DM instances.
- Grants at most one access per cycle and tracks a single outstanding read with fixed memory latency.
- Returns read data to the requester that issued the read.
- Data port has priority; an anti-starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width of both requesters and memory.
- DATA_W, 32, data width.
- LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..4.
- STARVE_MAX, 4, consecutive denied fetch-request cycles after which fetch wins the next grant; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  one-cycle pulse, fetch read data valid.
- if_rdata  out  DATA_W  fetch data; mem_rdata when if_rvalid, else 0.
- dm_req  in  1  data request; held with addr/w_en/wdata stable until dm_gnt.
- dm_addr  in  ADDR_W  data address.
- dm_w_en  in  4  byte write enables; 0 means read.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  data access accepted this cycle.
- dm_rvalid  out  1  one-cycle pulse, load data valid (reads only).
- dm_rdata  out  DATA_W  load data; mem_rdata when dm_rvalid, else 0.
- mem_en  out  1  memory access strobe.
- mem_w_en  out  4  byte write enables to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid LAT cycles after a read strobe.
- busy  out  1  a read is outstanding.

Behaviour:
- Reset (rst low, async):
  - state IDLE; lat_cnt, starve_cnt and owner cleared.
  - All outputs 0: gnts, rvalids, rdata, mem_en, mem_w_en, mem_addr, mem_wdata, busy.
  - A read in flight at reset is dropped; no rvalid after reset release.
- States: IDLE (no read outstanding) and WAIT (read outstanding).
- Grant window is open when state is IDLE, or state is WAIT with lat_cnt==1. The latter is the return cycle, so reads can issue back to back.
- Outside the grant window, if_gnt=dm_gnt=0 and mem_en=0.
- Arbitration (combinational, inside the grant window):
  - Only dm_req: dm wins.
  - Only if_req: if wins.
  - Both requesting: if wins when starve_cnt==STARVE_MAX, else dm wins.
- Grant cycle:
  - Winner's gnt=1 and mem_en=1 in the same cycle.
  - mem_addr, mem_w_en and mem_wdata are driven from the winner. Fetch always uses mem_w_en=0 and mem_wdata=0.
  - When there is no grant, mem_addr, mem_w_en and mem_wdata are 0.
- Writes (dm_w_en!=0): complete in the grant cycle; no rvalid; state is not changed by the write.
- Reads:
  - On grant: lat_cnt<=LAT, owner<=winner, state<=WAIT.
  - Each WAIT cycle decrements lat_cnt.
  - When lat_cnt==1, the owner's rvalid=1 and its rdata=mem_rdata.
  - Next state after the return cycle: WAIT (reloaded) if a new read is granted that cycle, else IDLE.
- busy=1 whenever state is WAIT.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle if_req=1 and if_gnt=0.
  - Clears on if_gnt or when if_req=0.
- Requester outputs: the non-owner's rvalid and rdata are always 0; the owner's rdata is 0 outside its rvalid cycle.
- A request deasserted before grant is a protocol violation; the arbiter simply re-arbitrates each cycle and holds no request state.

Test Plan:
- Reset: drive rst=0 mid-read (LAT=2, one cycle after a grant), release -> all outputs 0, no dm_rvalid ever appears, state IDLE; next if_req granted in its first cycle.
- Single fetch, LAT=1: if_req, if_addr=0x10 at cycle 0, mem_rdata=0xDEADBEEF at cycle 1 -> if_gnt at cycle 0, mem_addr=0x10, if_rvalid with if_rdata=0xDEADBEEF at cycle 1, busy=1 only at cycle 1.
- Priority: if_req and dm_req (read, dm_addr=0x100) both high at cycle 0, LAT=1 -> dm_gnt cycle 0, dm_rvalid cycle 1, if_gnt cycle 1, if_rvalid cycle 2.
- Starvation, STARVE_MAX=4: dm_req held continuously with writes (dm_w_en=0xF), if_req high -> if_gnt exactly in the 5th request cycle; dm_gnt in the other cycles; starve_cnt then restarts.
- Latency, LAT=3: two back-to-back dm reads to 0x0 and 0x4 -> grants at cycles 0 and 3; dm_rvalid at cycles 3 and 6; no grant at cycles 1-2 or 4-5.
- Store with byte enables: dm_w_en=0x3, dm_wdata=0x1234ABCD, dm_addr=0x20 -> in the grant cycle mem_w_en=0x3, mem_wdata=0x1234ABCD, mem_addr=0x20; no dm_rvalid; busy stays 0.
